// File: rtl/vga_source_select_if.sv
// Signal bundle between the pattern generators, the source selector and the board VGA pins.
// The master drives the sources and the select request; the slave is the selector.
interface vga_source_select_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned COLOR_W = 4
);
  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [SEL_W-1:0]           sel_req;
  logic [NUM_SRC*COLOR_W-1:0] src_red;
  logic [NUM_SRC*COLOR_W-1:0] src_green;
  logic [NUM_SRC*COLOR_W-1:0] src_blue;
  logic [NUM_SRC-1:0]         src_h_sync;
  logic [NUM_SRC-1:0]         src_v_sync;
  logic [NUM_SRC-1:0]         src_display_on;

  logic [COLOR_W-1:0]         vga_red;
  logic [COLOR_W-1:0]         vga_green;
  logic [COLOR_W-1:0]         vga_blue;
  logic                       h_sync;
  logic                       v_sync;
  logic [NUM_SRC-1:0]         led;
  logic                       switch_pending;
  logic                       forced_switch;

  modport master (
    output sel_req, src_red, src_green, src_blue, src_h_sync, src_v_sync, src_display_on,
    input  vga_red, vga_green, vga_blue, h_sync, v_sync, led, switch_pending, forced_switch
  );

  modport slave (
    input  sel_req, src_red, src_green, src_blue, src_h_sync, src_v_sync, src_display_on,
    output vga_red, vga_green, vga_blue, h_sync, v_sync, led, switch_pending, forced_switch
  );
endinterface

// File: rtl/vga_source_select.sv
// N-way VGA source selector: debounced select request, swap only at a vsync frame boundary of
// the displayed source (or after a timeout), registered outputs with blanking.
module vga_source_select #(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned COLOR_W         = 4,
  parameter bit          SYNC_ACTIVE     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
  input logic                clk,
  input logic                rst,
  vga_source_select_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  logic [SEL_W-1:0]   sync1_q, sync2_q;
  logic [SEL_W-1:0]   cand_q, cand_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  state_e             state_q, state_d;
  logic               forced_q, forced_d;
  logic               prev_vs_q;
  logic               cur_vs, vs_edge, timeout;

  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;
  logic               h_sync_q, v_sync_q;
  logic [NUM_SRC-1:0] led;

  // Debounce: target follows a candidate that has been stable long enough and is in range.
  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    target_d = target_q;
    if (sync2_q != cand_q) begin
      cand_d   = sync2_q;
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (db_cnt_d == DB_W'(DEBOUNCE_CYCLES - 1) && 32'(cand_d) < NUM_SRC) begin
      target_d = cand_d;
    end
  end

  // prev_vs_q still holds the old source's sample after a swap, so a swap cannot fake an edge.
  assign cur_vs  = bus.src_v_sync[active_q];
  assign vs_edge = (cur_vs == SYNC_ACTIVE) && (prev_vs_q != SYNC_ACTIVE);
  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    to_cnt_d = to_cnt_q;
    forced_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (target_q != active_q) begin
          state_d  = StPending;
          to_cnt_d = '0;
        end
      end
      StPending: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (target_q == active_q) begin
          state_d = StIdle;
        end else if (vs_edge || timeout) begin
          active_d = target_q;
          state_d  = StIdle;
          forced_d = timeout && !vs_edge;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (bus.src_display_on[active_q]) begin
      red_d   = bus.src_red[32'(active_q) * COLOR_W +: COLOR_W];
      green_d = bus.src_green[32'(active_q) * COLOR_W +: COLOR_W];
      blue_d  = bus.src_blue[32'(active_q) * COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    led = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      led[i] = (32'(active_q) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      db_cnt_q  <= '0;
      target_q  <= '0;
      active_q  <= '0;
      to_cnt_q  <= '0;
      state_q   <= StIdle;
      forced_q  <= 1'b0;
      prev_vs_q <= ~SYNC_ACTIVE;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      h_sync_q  <= ~SYNC_ACTIVE;
      v_sync_q  <= ~SYNC_ACTIVE;
    end else begin
      sync1_q   <= bus.sel_req;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      db_cnt_q  <= db_cnt_d;
      target_q  <= target_d;
      active_q  <= active_d;
      to_cnt_q  <= to_cnt_d;
      state_q   <= state_d;
      forced_q  <= forced_d;
      prev_vs_q <= cur_vs;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      h_sync_q  <= bus.src_h_sync[active_q];
      v_sync_q  <= cur_vs;
    end
  end

  assign bus.vga_red        = red_q;
  assign bus.vga_green      = green_q;
  assign bus.vga_blue       = blue_q;
  assign bus.h_sync         = h_sync_q;
  assign bus.v_sync         = v_sync_q;
  assign bus.led            = led;
  assign bus.switch_pending = (state_q == StPending);
  assign bus.forced_switch  = forced_q;
endmodule

// File: tb/tb_vga_source_select.sv
// Directed bench for vga_source_select: a 4-source instance for the main behaviour and a
// 3-source instance held on an out-of-range request.
module tb_vga_source_select;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_source_select_if #(.NUM_SRC(4), .COLOR_W(CW)) bus_a ();
  vga_source_select_if #(.NUM_SRC(3), .COLOR_W(CW)) bus_b ();

  vga_source_select #(
    .NUM_SRC(4), .COLOR_W(CW), .SYNC_ACTIVE(1'b0), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(64)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  vga_source_select #(
    .NUM_SRC(3), .COLOR_W(CW), .SYNC_ACTIVE(1'b0), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(64)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Source i colours: s0 r1 g8 bF, s1 r4 g9 bE, s2 r7 gA bD, s3 rA gB bC; syncs idle high.
  task automatic restore_a();
    bus_a.src_red        = 16'hA741;
    bus_a.src_green      = 16'hBA98;
    bus_a.src_blue       = 16'hCDEF;
    bus_a.src_h_sync     = 4'hF;
    bus_a.src_v_sync     = 4'hF;
    bus_a.src_display_on = 4'hF;
  endtask

  task automatic wait_pending(input string tag);
    int n;
    n = 0;
    while (bus_a.switch_pending !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, bus_a.switch_pending}, 32'd1);
  endtask

  initial begin
    logic seen;
    int   k;

    rst = 1'b1;
    bus_a.sel_req = 2'd0;
    restore_a();
    bus_b.sel_req        = 2'd3;
    bus_b.src_red        = 12'h321;
    bus_b.src_green      = 12'h654;
    bus_b.src_blue       = 12'h987;
    bus_b.src_h_sync     = 3'h7;
    bus_b.src_v_sync     = 3'h7;
    bus_b.src_display_on = 3'h7;

    // Reset held with the inputs toggling
    for (int i = 0; i < 3; i++) begin
      bus_a.src_red    = 16'($urandom);
      bus_a.src_green  = 16'($urandom);
      bus_a.src_blue   = 16'($urandom);
      bus_a.src_h_sync = 4'($urandom);
      bus_a.src_v_sync = 4'($urandom);
      tick();
    end
    check_eq("rst_red", bus_a.vga_red, 0);
    check_eq("rst_green", bus_a.vga_green, 0);
    check_eq("rst_blue", bus_a.vga_blue, 0);
    check_eq("rst_hs", bus_a.h_sync, 1);
    check_eq("rst_vs", bus_a.v_sync, 1);
    check_eq("rst_led", bus_a.led, 4'b0001);
    check_eq("rst_pend", bus_a.switch_pending, 0);
    check_eq("rst_forced", bus_a.forced_switch, 0);
    check_eq("rst_led_b", bus_b.led, 3'b001);

    rst = 1'b0;
    restore_a();
    check_eq("lat_pre", bus_a.vga_red, 0);
    tick();
    check_eq("lat_red", bus_a.vga_red, 4'h1);
    check_eq("lat_green", bus_a.vga_green, 4'h8);
    check_eq("lat_blue", bus_a.vga_blue, 4'hF);
    bus_a.src_red[3:0]  = 4'h5;
    bus_a.src_h_sync[0] = 1'b0;
    tick();
    check_eq("pass_red", bus_a.vga_red, 4'h5);
    check_eq("pass_hs", bus_a.h_sync, 0);
    restore_a();
    tick();

    // Debounced switch 0 -> 2, swap waits for source 0's vsync
    bus_a.sel_req = 2'd2;
    ticks(17);
    check_eq("db_early", bus_a.switch_pending, 0);
    ticks(2);
    check_eq("db_pend", bus_a.switch_pending, 1);
    check_eq("db_led", bus_a.led, 4'b0001);
    ticks(5);
    check_eq("hold_led", bus_a.led, 4'b0001);
    check_eq("hold_red", bus_a.vga_red, 4'h1);
    bus_a.src_v_sync[0] = 1'b0;
    tick();
    check_eq("swap_led", bus_a.led, 4'b0100);
    check_eq("swap_pend", bus_a.switch_pending, 0);
    check_eq("swap_forced", bus_a.forced_switch, 0);
    check_eq("swap_red_old", bus_a.vga_red, 4'h1);
    restore_a();
    tick();
    check_eq("new_red", bus_a.vga_red, 4'h7);
    check_eq("new_green", bus_a.vga_green, 4'hA);
    check_eq("new_blue", bus_a.vga_blue, 4'hD);

    // Glitch on sel_req shorter than the debounce window
    bus_a.sel_req = 2'd3;
    ticks(10);
    bus_a.sel_req = 2'd2;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | bus_a.switch_pending;
    end
    check_eq("glitch_pend", seen, 0);
    check_eq("glitch_led", bus_a.led, 4'b0100);

    // Timeout with source 2's vsync stuck idle
    bus_a.sel_req = 2'd1;
    wait_pending("to_pend");
    k = 0;
    while (bus_a.forced_switch !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    check_eq("to_cycles", k, 64);
    check_eq("to_led", bus_a.led, 4'b0010);
    check_eq("to_pend_clr", bus_a.switch_pending, 0);
    tick();
    check_eq("to_pulse_len", bus_a.forced_switch, 0);

    check_eq("oor_led_mid", bus_b.led, 3'b001);
    check_eq("oor_pend_mid", bus_b.switch_pending, 0);

    // Vsync edge in the same cycle as the timeout: one normal swap
    bus_a.sel_req = 2'd0;
    wait_pending("tie_pend");
    seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      seen = seen | bus_a.forced_switch;
    end
    check_eq("tie_early", seen, 0);
    check_eq("tie_led_pre", bus_a.led, 4'b0010);
    bus_a.src_v_sync[1] = 1'b0;
    tick();
    check_eq("tie_led", bus_a.led, 4'b0001);
    check_eq("tie_forced", bus_a.forced_switch, 0);
    check_eq("tie_pend", bus_a.switch_pending, 0);
    restore_a();
    tick();
    check_eq("tie_forced_after", bus_a.forced_switch, 0);

    // Blanking: colour zeroed, syncs still routed
    bus_a.src_display_on[0] = 1'b0;
    bus_a.src_h_sync[0]     = 1'b0;
    bus_a.src_v_sync[0]     = 1'b0;
    tick();
    check_eq("blank_red", bus_a.vga_red, 0);
    check_eq("blank_green", bus_a.vga_green, 0);
    check_eq("blank_blue", bus_a.vga_blue, 0);
    check_eq("blank_hs", bus_a.h_sync, 0);
    check_eq("blank_vs", bus_a.v_sync, 0);
    restore_a();
    tick();
    check_eq("unblank_red", bus_a.vga_red, 4'h1);

    // Reset while pending discards the request
    bus_a.sel_req = 2'd3;
    wait_pending("mr_pend");
    rst = 1'b1;
    bus_a.sel_req = 2'd0;
    tick();
    check_eq("mr_pend_clr", bus_a.switch_pending, 0);
    check_eq("mr_led", bus_a.led, 4'b0001);
    rst = 1'b0;
    ticks(3);
    bus_a.src_v_sync[0] = 1'b0;
    tick();
    bus_a.src_v_sync[0] = 1'b1;
    ticks(40);
    check_eq("mr_led_late", bus_a.led, 4'b0001);
    check_eq("mr_pend_late", bus_a.switch_pending, 0);

    check_eq("oor_led", bus_b.led, 3'b001);
    check_eq("oor_pend", bus_b.switch_pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
